regfile16: RTL
==============

# regfile16

Sixteen-entry, 16-bit general-purpose register file for the single-cycle CPU datapath, sitting directly upstream of the 16-bit 2:1 operand-select muxes. Read port 1 drives ALU operand A. Read port 2 drives the `d1` input of the ALU-source mux. Write-back data is committed on the rising clock edge. Register 0 reads as constant zero, and an optional write-through bypass lets a same-cycle write appear on the read ports.

## Interface
Parameters:
- `WIDTH`, 16, data width of each register and port.
- `AW`, 4, address width; depth = 2^AW = 16 entries.
- `ZERO_REG`, 1, 1 = entry 0 hardwired to zero and writes to it ignored; 0 = entry 0 is ordinary storage.
- `BYPASS`, 1, 1 = read of the address being written returns `wdata` combinationally; 0 = read returns the stored (old) value until the edge.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset, sampled on rising `clk`.
- `we`  in  1  write enable.
- `waddr`  in  AW  write address.
- `wdata`  in  WIDTH  write data.
- `raddr1`  in  AW  read address, port 1.
- `raddr2`  in  AW  read address, port 2.
- `rdata1`  out  WIDTH  read data, port 1 (combinational).
- `rdata2`  out  WIDTH  read data, port 2 (combinational).
- `wr_count`  out  16  number of committed writes since reset; saturates at 16'hFFFF.

## Operation
- Storage: array of 2^AW registers, each WIDTH bits, plus the `wr_count` counter.
- Write commit happens on a rising `clk` edge when `rst_n`=1, `we`=1, and not (`ZERO_REG`=1 and `waddr`=0). On commit, `mem[waddr]` <= `wdata` and `wr_count` increments, saturating at 16'hFFFF.
- A suppressed write does not change storage and does not increment `wr_count`. Writes are suppressed when `we`=0, when the target is zero-register 0, or when reset is asserted.
- Read (each port independently, purely combinational):
  - if `ZERO_REG`=1 and raddr=0: return 0;
  - else if `BYPASS`=1, `rst_n`=1, `we`=1 and raddr=`waddr`: return `wdata`;
  - else return `mem[raddr]`.
- Both read ports may address the same entry. Both may also hit the bypass at the same time and then return identical data.
- Reset: on a rising edge with `rst_n`=0, all entries are cleared to 0 and `wr_count` is set to 0. Any concurrent `we` is ignored.
  - Reset has priority over write in every case.
  - Reset mid-stream, for example between two back-to-back writes, discards the pending write entirely.
- There is no X-propagation tolerance. Any out-of-range address is impossible by construction (2^AW entries).

## Timing
- Write latency is 1 edge. Data written at edge N is visible from `mem` after edge N.
  - With `BYPASS`=1 it is already visible on `rdata*` during the cycle before edge N.
- Read latency is 0 cycles, combinational from `raddr*`, `mem`, and (bypass) `we`/`waddr`/`wdata`.
- After a reset edge, `rdata1`, `rdata2` and `wr_count` are all 0.
- While `rst_n`=0 (before the edge), reads return the current stored contents and the bypass is disabled.
- `wr_count` updates on the same edge as the write it counts.
- Back-to-back writes to the same address on consecutive edges: the last one wins. Each write counts once.

## Test plan
- Reset, then read: hold `rst_n`=0 for 1 edge with `we`=1, `waddr`=3, `wdata`=16'hAAAA, then read raddr1=3 and raddr2=15 -> both 0, `wr_count`=0.
- Write/read-back: write 16'h1234 to r5 and 16'hBEEF to r10, then set raddr1=5 and raddr2=10 -> `rdata1`=16'h1234, `rdata2`=16'hBEEF, `wr_count`=2.
- Zero register (`ZERO_REG`=1): write 16'hFFFF to r0, then read r0 on both ports -> 0, `wr_count` unchanged.
- Bypass: with r7=16'h0001, drive `we`=1, `waddr`=7, `wdata`=16'h00F0, raddr1=raddr2=7 before the edge.
  - `BYPASS`=1 -> both ports read 16'h00F0 pre-edge.
  - `BYPASS`=0 -> both ports read 16'h0001 pre-edge and 16'h00F0 post-edge.
- Reset beats write: with r2=16'h5555, assert `rst_n`=0 with `we`=1, `waddr`=2, `wdata`=16'h7777 on one edge -> r2=0, `wr_count`=0. Also check r2 reads 16'h5555 before that edge.
- Counter saturation: preload by performing 65535 writes to r1 -> `wr_count`=16'hFFFF. One more write -> `wr_count` stays 16'hFFFF and r1 holds the new data.

Source files
------------

// File: rtl/regfile16.sv
// regfile16: 2^AW x WIDTH general-purpose register file for the single-cycle
// CPU datapath. One write port commits on the rising edge. Two read ports are
// combinational. Entry 0 can be hardwired to zero. An optional write-through
// bypass forwards same-cycle write data to the read ports. A saturating
// counter tracks committed writes since reset.
module regfile16 #(
    parameter int WIDTH    = 16,
    parameter int AW       = 4,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr1,
    input  logic [AW-1:0]    raddr2,
    output logic [WIDTH-1:0] rdata1,
    output logic [WIDTH-1:0] rdata2,
    output logic [15:0]      wr_count
);

    localparam int DEPTH = 1 << AW;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [15:0]      wr_count_q;
    logic [15:0]      wr_count_d;
    logic             commit;

    // Next-state for storage and the write counter; reset priority lives in the flop block.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
        mem_d      = mem_q;
        wr_count_d = wr_count_q;
        commit     = we && !(ZERO_REG && (waddr == '0));
        if (commit) begin
            mem_d[waddr] = wdata;
            if (wr_count_q != 16'hFFFF) begin
                wr_count_d = wr_count_q + 16'd1;
            end
        end
    end

    // State registers with synchronous active-low reset that overrides any write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: the storage array is deliberately cleared on reset because reads after reset must return zero; this rules out a plain RAM macro.
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_count_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            mem_q      <= mem_d;
            wr_count_q <= wr_count_d;
        end
    end

    // Read port 1: zero register first, then bypass of the live write, then storage.
    always_comb begin
        rdata1 = mem_q[raddr1];
        if (ZERO_REG && (raddr1 == '0)) begin
            rdata1 = '0;
        end else if (BYPASS && rst_n && we && (raddr1 == waddr)) begin
            rdata1 = wdata;
        end
    end

    // Read port 2: same priority as port 1, evaluated independently.
    always_comb begin
        rdata2 = mem_q[raddr2];
        if (ZERO_REG && (raddr2 == '0)) begin
            rdata2 = '0;
        end else if (BYPASS && rst_n && we && (raddr2 == waddr)) begin
            rdata2 = wdata;
        end
    end

    assign wr_count = wr_count_q;

endmodule
